gpio_bank: RTL

//  Parametrised bidirectional GPIO bank on the core's 8-bit-style register bus, widened to WIDTH pins.
//  Per-pin output data, direction, 2-flop input synchroniser, atomic set/clear writes and

---
 rtl/gpio_bank.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
//   Parametrised bidirectional GPIO bank on the core register bus.
//   Each pin has output data, a direction bit, a 2-flop input synchroniser,
//   atomic set/clear writes and an edge-triggered interrupt with sticky
//   write-1-to-clear status.
//
// Optional build macro:
//   GPIO_DEBOUNCE_EN - adds a per-pin stability filter of DEB_CYCLES cycles
//                      between the synchroniser and the IN / edge-detect path.
//
// Parameters:
//   WIDTH      - number of pins (1..32)
//   DEB_CYCLES - debounce window in clk cycles (>=2, debounce build only)
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   we       in   1      register write strobe
//   addr     in   3      register select
//   wdata    in   WIDTH  write data
//   rdata    out  WIDTH  read data (combinational)
//   gpio_in  in   WIDTH  asynchronous pad inputs
//   gpio_out out  WIDTH  pad output data
//   gpio_oe  out  WIDTH  pad output enable, 1 = drive
//   irq      out  1      level interrupt, |(IRQ_STAT & IRQ_EN)
//
// Register map: 0 OUT rw | 1 DIR rw | 2 IN ro | 3 SET wo | 4 CLR wo |
//               5 IRQ_EN rw | 6 IRQ_EDGE rw (1=rising) | 7 IRQ_STAT rw1c
// -----------------------------------------------------------------------------
module gpio_bank #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "gpio_bank: WIDTH must be 1..32");
    end
    if (DEB_CYCLES < 2) begin : g_bad_deb
        $fatal(1, "gpio_bank: DEB_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        A_OUT      = 3'd0,
        A_DIR      = 3'd1,
        A_IN       = 3'd2,
        A_SET      = 3'd3,
        A_CLR      = 3'd4,
        A_IRQ_EN   = 3'd5,
        A_IRQ_EDGE = 3'd6,
        A_IRQ_STAT = 3'd7
    } addr_e;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_irq_edge;
    logic [WIDTH-1:0] r_irq_stat;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_stat_clr;

    // Control registers. SET/CLR are read-modify-write on OUT so software can
    // flip single pins without a racy read-then-write sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
        end else if (we) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so order of statements never matters here.
            unique case (addr_e'(addr))
                A_OUT:      r_out      <= wdata;
                A_DIR:      r_dir      <= wdata;
                A_SET:      r_out      <= r_out | wdata;
                A_CLR:      r_out      <= r_out & ~wdata;
                A_IRQ_EN:   r_irq_en   <= wdata;
                A_IRQ_EDGE: r_irq_edge <= wdata;
                default:    ;   // IN is read-only, IRQ_STAT handled below
            endcase
        end
    end

    // Two-flop synchroniser plus the previous filtered sample for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_prev  <= w_filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0] r_deb;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // A pin's debounced value only follows sync2 after it has disagreed for
    // DEB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_filt = r_deb;
`else
    assign w_filt = r_sync2;
`endif

    // Edge detection ignores IRQ_EN and DIR: the enable only masks irq, and
    // driven pins are seen through the pad loopback like any other input.
    assign w_evt = ( r_irq_edge & w_filt & ~r_prev)
                 | (~r_irq_edge & ~w_filt & r_prev);

    assign w_stat_clr = (we && addr_e'(addr) == A_IRQ_STAT) ? wdata : '0;

    // A new event in the same cycle as a W1C on that bit wins, so no edge is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq_stat <= '0;
        else        r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_evt;
    end

    always_comb begin
        // NOTE: default assignment first so every path drives rdata and no
        // latch is inferred for the write-only addresses.
        rdata = '0;
        unique case (addr_e'(addr))
            A_OUT:      rdata = r_out;
            A_DIR:      rdata = r_dir;
            A_IN:       rdata = w_filt;
            A_IRQ_EN:   rdata = r_irq_en;
            A_IRQ_EDGE: rdata = r_irq_edge;
            A_IRQ_STAT: rdata = r_irq_stat;
            default:    rdata = '0;
        endcase
    end

    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_irq_stat & r_irq_en);

endmodule
